// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : AES-128 datapath widths and input_interface state encoding
// Rev 1.0
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTES   = 16;
    localparam int DATA_W      = 8;

    localparam logic [1:0] S_RECV_KEY  = 2'd0;
    localparam logic [1:0] S_RECV_TEXT = 2'd1;
    localparam logic [1:0] S_HOLD      = 2'd2;

    typedef enum logic [1:0] {
        ST_RECV_KEY  = S_RECV_KEY,
        ST_RECV_TEXT = S_RECV_TEXT,
        ST_HOLD      = S_HOLD
    } in_state_t;

endpackage
`default_nettype wire

// File: rtl/input_interface_if.sv
`default_nettype none
// ============================================================================
// input_interface_if : byte stream in, assembled key/plaintext handshake out
// Rev 1.0
// ============================================================================
interface input_interface_if;
    import aes_pkg::*;

    logic [DATA_W-1:0]      data_in;
    logic                   data_valid;
    logic                   new_key;
    logic                   transformer_ack;
    logic                   input_ready;
    logic [AES_BLOCK_W-1:0] key;
    logic [AES_BLOCK_W-1:0] plaintext;
    logic                   data_loaded;
    logic                   key_valid;

    modport master (
        output data_in, data_valid, new_key, transformer_ack,
        input  input_ready, key, plaintext, data_loaded, key_valid
    );

    modport slave (
        input  data_in, data_valid, new_key, transformer_ack,
        output input_ready, key, plaintext, data_loaded, key_valid
    );

endinterface
`default_nettype wire

// File: rtl/input_interface.sv
`default_nettype none
// ============================================================================
// input_interface : assembles a 128-bit key and plaintext from a byte stream,
//                   first byte in bits [127:120]; level-valid / pulse-ack out
// Rev 1.0
// ============================================================================
module input_interface #(
    parameter int BLOCK_BYTES = 16,
    parameter int DATA_W      = 8
) (
    input  wire                clk,
    input  wire                rst_,
    input_interface_if.slave   bus
);
    localparam int CNT_W = $clog2(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] c_last_byte = CNT_W'(BLOCK_BYTES - 1);
    localparam int BLK_W = BLOCK_BYTES * DATA_W;

    aes_pkg::in_state_t state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               loaded_q, loaded_d;
    logic               kvalid_q, kvalid_d;
    logic [BLK_W-1:0]   key_q;
    logic [BLK_W-1:0]   pt_q;
    logic               w_accept;

    // Input is refused in HOLD, which also makes a same-cycle ack+byte drop the byte.
    assign w_accept = bus.data_valid && (state_q != aes_pkg::ST_HOLD);

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q  <= aes_pkg::ST_RECV_KEY;
            cnt_q    <= '0;
            loaded_q <= 1'b0;
            kvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
            kvalid_q <= kvalid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        kvalid_d = kvalid_q;
        case (state_q)
            aes_pkg::ST_RECV_KEY: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_last_byte) begin
                        state_d  = aes_pkg::ST_RECV_TEXT;
                        kvalid_d = 1'b1;
                    end
                end
            end
            aes_pkg::ST_RECV_TEXT: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == c_last_byte) begin
                        state_d  = aes_pkg::ST_HOLD;
                        loaded_d = 1'b1;
                    end
                end
            end
            aes_pkg::ST_HOLD: begin
                if (bus.transformer_ack) begin
                    loaded_d = 1'b0;
                    state_d  = (bus.new_key || !kvalid_q) ? aes_pkg::ST_RECV_KEY
                                                          : aes_pkg::ST_RECV_TEXT;
                end
            end
            default: state_d = aes_pkg::ST_RECV_KEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            key_q <= '0;
        end else if (w_accept && state_q == aes_pkg::ST_RECV_KEY) begin
            key_q <= {key_q[BLK_W-DATA_W-1:0], bus.data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            pt_q <= '0;
        end else if (w_accept && state_q == aes_pkg::ST_RECV_TEXT) begin
            pt_q <= {pt_q[BLK_W-DATA_W-1:0], bus.data_in};
        end
    end

    assign bus.input_ready = (state_q != aes_pkg::ST_HOLD);
    assign bus.key         = key_q;
    assign bus.plaintext   = pt_q;
    assign bus.data_loaded = loaded_q;
    assign bus.key_valid   = kvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_input_interface.sv
`default_nettype none
// ============================================================================
// tb_input_interface : directed frame table plus HOLD / reset corner sequences
// Rev 1.0
// ============================================================================
module tb_input_interface;
    import aes_pkg::*;

    localparam logic [127:0] c_K = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] c_P = 128'h3243F6A8885A308D313198A2E0370734;
    localparam logic [127:0] c_Q = 128'h00112233445566778899AABBCCDDEEFF;

    logic clk;
    logic rst_;
    input_interface_if bus();

    input_interface u_dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic         do_reset;
        logic         new_key;
        logic         gapped;
        logic [127:0] key_in;
        logic [127:0] pt_in;
        logic [127:0] exp_key;
        logic [127:0] exp_pt;
    } frame_t;

    frame_t tbl [3];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_ = 1'b1;
        tick();
        rst_ = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gapped);
        bus.data_in    = b;
        bus.data_valid = 1'b1;
        tick();
        if (gapped) begin
            bus.data_valid = 1'b0;
            tick();
        end
    endtask

    // data_loaded must still be low after byte 15 of the text and high right after byte 16.
    task automatic stream_frame(input string tag, input logic with_key, input logic [127:0] k,
                                input logic [127:0] p, input logic gapped);
        if (with_key) begin
            for (int i = 0; i < 16; i++) begin
                send_byte(k[127-8*i -: 8], gapped);
                if (gapped && i == 7) repeat (10) tick();
            end
            check_bit({tag, " key_valid after key"}, bus.key_valid, 1'b1);
            check_bit({tag, " ready after key"}, bus.input_ready, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            send_byte(p[127-8*i -: 8], gapped);
            if (i == 14) begin
                check_bit({tag, " loaded before last"}, bus.data_loaded, 1'b0);
                check_bit({tag, " ready before last"}, bus.input_ready, 1'b1);
            end
        end
        bus.data_valid = 1'b0;
        check_bit({tag, " loaded at last"}, bus.data_loaded, 1'b1);
        check_bit({tag, " ready in hold"}, bus.input_ready, 1'b0);
    endtask

    task automatic ack(input logic nk, input logic dv);
        bus.new_key         = nk;
        bus.transformer_ack = 1'b1;
        bus.data_valid      = dv;
        bus.data_in         = 8'hFF;
        tick();
        bus.transformer_ack = 1'b0;
        bus.data_valid      = 1'b0;
    endtask

    initial begin
        logic with_key;
        string tag;
        rst_                = 1'b0;
        bus.data_in         = '0;
        bus.data_valid      = 1'b0;
        bus.new_key         = 1'b0;
        bus.transformer_ack = 1'b0;

        tbl[0] = '{1'b1, 1'b1, 1'b0, c_K, c_P, c_K, c_P};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 128'h0, c_Q, c_K, c_Q};
        tbl[2] = '{1'b1, 1'b0, 1'b1, c_K, c_P, c_K, c_P};

        do_reset();
        check("reset key", bus.key, 128'h0);
        check("reset plaintext", bus.plaintext, 128'h0);
        check_bit("reset loaded", bus.data_loaded, 1'b0);
        check_bit("reset key_valid", bus.key_valid, 1'b0);
        check_bit("reset ready", bus.input_ready, 1'b1);

        for (int i = 0; i < 3; i++) begin
            tag = $sformatf("frame%0d", i);
            if (tbl[i].do_reset) begin
                do_reset();
                bus.new_key = tbl[i].new_key;
                with_key    = 1'b1;
            end else begin
                ack(tbl[i].new_key, 1'b0);
                check_bit({tag, " loaded after ack"}, bus.data_loaded, 1'b0);
                check_bit({tag, " ready after ack"}, bus.input_ready, 1'b1);
                with_key = tbl[i].new_key;
            end
            stream_frame(tag, with_key, tbl[i].key_in, tbl[i].pt_in, tbl[i].gapped);
            tick();
            check_bit({tag, " loaded held"}, bus.data_loaded, 1'b1);
            check({tag, " key"}, bus.key, tbl[i].exp_key);
            check({tag, " plaintext"}, bus.plaintext, tbl[i].exp_pt);
        end

        // HOLD must ignore incoming bytes, including one coincident with the ack.
        for (int i = 0; i < 5; i++) begin
            bus.data_in    = 8'hFF;
            bus.data_valid = 1'b1;
            tick();
            check("hold plaintext", bus.plaintext, c_P);
            check_bit("hold ready", bus.input_ready, 1'b0);
        end
        ack(1'b0, 1'b1);
        check_bit("ack+valid loaded", bus.data_loaded, 1'b0);
        check_bit("ack+valid ready", bus.input_ready, 1'b1);
        check("ack+valid plaintext", bus.plaintext, c_P);
        check("ack+valid key", bus.key, c_K);
        stream_frame("reuse after hold", 1'b0, c_K, c_Q, 1'b0);
        check("reuse key", bus.key, c_K);
        check("reuse plaintext", bus.plaintext, c_Q);

        // Reset with a partial text frame in flight and data_valid still high.
        ack(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) send_byte(c_P[127-8*i -: 8], 1'b0);
        bus.data_in = 8'hAA;
        do_reset();
        bus.data_valid = 1'b0;
        check("midreset key", bus.key, 128'h0);
        check("midreset plaintext", bus.plaintext, 128'h0);
        check_bit("midreset key_valid", bus.key_valid, 1'b0);
        check_bit("midreset loaded", bus.data_loaded, 1'b0);
        check_bit("midreset ready", bus.input_ready, 1'b1);
        bus.new_key = 1'b0;
        stream_frame("post reset", 1'b1, c_K, c_P, 1'b0);
        check("post reset key", bus.key, c_K);
        check("post reset plaintext", bus.plaintext, c_P);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
